load_seq_unit: RTL and testbench
================================

LOAD_SEQ_UNIT -- requirements
Module: load_seq_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning the data and address width; the only legal values are 32 and 64.
REQ-002 The module SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request.
- funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- addr  in  XLEN  byte address, already computed as rs1+imm.
- rd_idx  in  5  destination register tag.
- mem_req  out  1  memory read request.
- mem_addr  out  XLEN  word-aligned address, with the low log2(XLEN/8) bits equal to 0.
- mem_gnt  in  1  request accepted by memory.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data, little-endian.
- rsp_valid  out  1  result valid.
- rsp_data  out  XLEN  extended load result.
- rsp_rd  out  5  echoed rd_idx.
- rsp_fault  out  1  illegal or misaligned access.
- rsp_ready  in  1  consumer accepts the result.

Function
REQ-003 The FSM SHALL have exactly six states: IDLE, REQ1, WAIT1, REQ2, WAIT2 and RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1; funct3, addr and rd_idx are registered on acceptance.
REQ-005 Access size SHALL be 1, 2, 4 or 8 bytes; LD and LWU are legal only when XLEN=64 and fault otherwise; funct3 111 always faults.
REQ-006 A faulting request SHALL go IDLE->RESP with rsp_fault=1 and rsp_data=0, and SHALL NOT raise mem_req.
REQ-007 A legal request SHALL go IDLE->REQ1; mem_req=1 in REQ1 and REQ2; mem_req and mem_addr SHALL be held stable until mem_gnt=1.
REQ-008 On mem_gnt the FSM SHALL move REQ1->WAIT1 (or REQ2->WAIT2); mem_gnt in any other state SHALL be ignored.
REQ-009 In WAIT1, mem_rvalid SHALL capture beat 0 and move to REQ2 if the access crosses an XLEN/8-byte boundary, otherwise to RESP.
REQ-010 In WAIT2, mem_rvalid SHALL capture beat 1 and move to RESP; the REQ2 address is the REQ1 address plus XLEN/8, wrapping modulo 2^XLEN.
REQ-011 Byte extraction SHALL select size bytes starting at addr offset from the concatenation {beat1, beat0}, little-endian.
REQ-012 LB, LH, LW SHALL sign-extend to XLEN; LBU, LHU, LWU SHALL zero-extend; LD passes the data unchanged.
REQ-013 rsp_valid SHALL be 1 only in RESP, and rsp_data, rsp_rd and rsp_fault SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-014 RESP->IDLE SHALL occur when rsp_ready=1; a new request SHALL NOT be accepted in that same cycle.
REQ-015 Minimum latency for an aligned load SHALL be: accept at edge T, mem_req in cycle T+1 (granted), mem_rvalid in cycle T+2, rsp_valid in cycle T+3.
REQ-016 mem_rvalid outside WAIT1 or WAIT2 SHALL be ignored.

Reset
REQ-017 When reset=1 at a rising edge, the FSM SHALL enter IDLE from any state and abandon any in-flight access.
REQ-018 After reset, all outputs SHALL be: req_ready=1, mem_req=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_fault=0.
REQ-019 The memory side SHALL share the same reset; a stale mem_rvalid arriving after reset SHALL NOT produce a response.

Configuration
REQ-020 Macro MISALIGNED_SPLIT_EN: when defined, misaligned accesses SHALL be serviced per REQ-009 through REQ-011; a misalignment within one word takes one beat and a boundary-crossing one takes two.
REQ-021 When MISALIGNED_SPLIT_EN is undefined, any addr not a multiple of the access size SHALL fault per REQ-006, and REQ2 and WAIT2 SHALL be unreachable.

Verification
REQ-022 XLEN=32, LB addr 0x1002, mem_rdata 0x80FF1234 -> mem_addr 0x1000, rsp_data 0xFFFFFFFF, rsp_valid at T+3.
REQ-023 Same stimulus with LBU -> rsp_data 0x000000FF; LHU addr 0x1002 -> 0x000080FF; LH addr 0x1002 -> 0xFFFF80FF.
REQ-024 MISALIGNED_SPLIT_EN defined, LH addr 0x1003, beat0 0xAB000000, beat1 0x000000CD -> mem_addr 0x1000 then 0x1004, rsp_data 0xFFFFCDAB; undefined -> rsp_fault=1, rsp_data 0, mem_req never 1.
REQ-025 XLEN=32, funct3 011 -> rsp_fault=1 one cycle after acceptance; funct3 111 -> same.
REQ-026 mem_gnt held low for 4 cycles -> mem_req and mem_addr stable; rsp_ready low for 3 cycles in RESP -> rsp_* stable and req_ready=0.
REQ-027 reset asserted in WAIT1, then mem_rvalid pulsed -> IDLE, rsp_valid stays 0, and the next LW addr 0x2000 (rdata 0x12345678) -> rsp_data 0x12345678.

Source files
------------

// File: rtl/load_seq_unit_if.sv
// load_seq_unit_if: request, memory and response signals of the load sequencer.
// "slave" is the unit's view; "master" is the surrounding environment
// (requesting core, memory and result consumer).
interface load_seq_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [4:0]      rd_idx;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic [4:0]      rsp_rd;
  logic            rsp_fault;
  logic            rsp_ready;

  modport slave (
    input  req_valid, funct3, addr, rd_idx, mem_gnt, mem_rvalid, mem_rdata, rsp_ready,
    output req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_fault
  );

  modport master (
    output req_valid, funct3, addr, rd_idx, mem_gnt, mem_rvalid, mem_rdata, rsp_ready,
    input  req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_fault
  );
endinterface

// File: rtl/load_seq_unit.sv
// load_seq_unit: sequences one RISC-V style load at a time onto a word-wide
// memory port, extracts and extends the addressed bytes, and returns the result.
// Optional feature macro MISALIGNED_SPLIT_EN: when defined, misaligned loads are
// serviced (one beat inside a word, two beats across a word boundary); when
// undefined, any misaligned load faults and the second-beat states are never used.
module load_seq_unit #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           reset,
  load_seq_unit_if.slave bus
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t          state_r;
  logic [2:0]      funct3_r;
  logic [XLEN-1:0] addr_r;
  logic [4:0]      rd_r;
  logic [XLEN-1:0] beat0_r;

  logic            req_fault_s;
  logic            cross_s;
  logic [XLEN-1:0] line_addr_s;

  // Access size in bytes from the low two funct3 bits (1, 2, 4 or 8).
  function automatic logic [4:0] size_of(input logic [2:0] f3);
    logic [4:0] sz;
    case (f3[1:0])
      2'b00:   sz = 5'd1;
      2'b01:   sz = 5'd2;
      2'b10:   sz = 5'd4;
      default: sz = 5'd8;
    endcase
    return sz;
  endfunction

  // Encodings that can never be serviced at this XLEN.
  function automatic logic illegal_op(input logic [2:0] f3);
    logic bad;
    if (f3 == 3'b111) begin
      bad = 1'b1;
    end else if ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110))) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  // Pick size bytes at byte offset off out of {beat1, beat0} and extend:
  // the field is pushed to the top of the word and shifted back down,
  // arithmetically for signed loads. LD has no padding so it passes unchanged.
  function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] dbl,
                                              input logic [OFFW-1:0]   off,
                                              input logic [2:0]        f3);
    logic [XLEN-1:0] low;
    logic [XLEN-1:0] res;
    int              pad;
    low = XLEN'(dbl >> {off, 3'b000});
    pad = XLEN - 8 * int'(size_of(f3));
    if (pad < 0) begin
      pad = 0;
    end else begin
      pad = pad;
    end
    low = low << pad;
    if (f3[2]) begin
      res = low >> pad;
    end else begin
      res = $signed(low) >>> pad;
    end
    return res;
  endfunction

`ifndef MISALIGNED_SPLIT_EN
  logic misaligned_s;

  // Without splitting support the address must be a multiple of the size.
  always_comb begin
    misaligned_s = ((5'(bus.addr[OFFW-1:0]) & (size_of(bus.funct3) - 5'd1)) != 5'd0);
  end
`endif

  // Classify the incoming request and compute the word-aligned first address.
  always_comb begin
`ifdef MISALIGNED_SPLIT_EN
    req_fault_s = illegal_op(bus.funct3);
`else
    req_fault_s = illegal_op(bus.funct3) | misaligned_s;
`endif
    line_addr_s = {bus.addr[XLEN-1:OFFW], {OFFW{1'b0}}};
  end

  // A second beat is needed when the accepted access runs past its word.
  always_comb begin
`ifdef MISALIGNED_SPLIT_EN
    cross_s = ((5'(addr_r[OFFW-1:0]) + size_of(funct3_r)) > 5'(NB));
`else
    cross_s = 1'b0;
`endif
  end

  // Load sequencer FSM; every interface output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      funct3_r       <= 3'd0;
      addr_r         <= {XLEN{1'b0}};
      rd_r           <= 5'd0;
      beat0_r        <= {XLEN{1'b0}};
      bus.req_ready  <= 1'b1;
      bus.mem_req    <= 1'b0;
      bus.mem_addr   <= {XLEN{1'b0}};
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= {XLEN{1'b0}};
      bus.rsp_rd     <= 5'd0;
      bus.rsp_fault  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            funct3_r      <= bus.funct3;
            addr_r        <= bus.addr;
            rd_r          <= bus.rd_idx;
            bus.req_ready <= 1'b0;
            if (req_fault_s) begin
              // Faults answer immediately and never touch memory.
              state_r       <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_fault <= 1'b1;
              bus.rsp_data  <= {XLEN{1'b0}};
              bus.rsp_rd    <= bus.rd_idx;
            end else begin
              state_r      <= REQ1;
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= line_addr_s;
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        REQ1: begin
          if (bus.mem_gnt) begin
            state_r     <= WAIT1;
            bus.mem_req <= 1'b0;
          end else begin
            state_r <= REQ1;
          end
        end
        WAIT1: begin
          if (bus.mem_rvalid) begin
            if (cross_s) begin
              // Next word wraps naturally at the top of the address space.
              state_r      <= REQ2;
              beat0_r      <= bus.mem_rdata;
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= bus.mem_addr + XLEN'(NB);
            end else begin
              state_r       <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_fault <= 1'b0;
              bus.rsp_rd    <= rd_r;
              bus.rsp_data  <= extract({{XLEN{1'b0}}, bus.mem_rdata},
                                       addr_r[OFFW-1:0], funct3_r);
            end
          end else begin
            state_r <= WAIT1;
          end
        end
        REQ2: begin
          if (bus.mem_gnt) begin
            state_r     <= WAIT2;
            bus.mem_req <= 1'b0;
          end else begin
            state_r <= REQ2;
          end
        end
        WAIT2: begin
          if (bus.mem_rvalid) begin
            state_r       <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_fault <= 1'b0;
            bus.rsp_rd    <= rd_r;
            bus.rsp_data  <= extract({bus.mem_rdata, beat0_r},
                                     addr_r[OFFW-1:0], funct3_r);
          end else begin
            state_r <= WAIT2;
          end
        end
        RESP: begin
          // req_ready rises only in the following cycle, so no request can
          // be taken in the same cycle the result is consumed.
          if (bus.rsp_ready) begin
            state_r       <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r       <= IDLE;
          bus.req_ready <= 1'b1;
          bus.mem_req   <= 1'b0;
          bus.rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_seq_unit.sv
// tb_load_seq_unit: directed and randomized checks of load_seq_unit at XLEN=32.
// The reference model follows MISALIGNED_SPLIT_EN the same way as the design.
module tb_load_seq_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  load_seq_unit_if #(.XLEN(32)) bus ();

  load_seq_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_m(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit fault_m(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd7 || f3 == 3'd3 || f3 == 3'd6) return 1'b1;
`ifndef MISALIGNED_SPLIT_EN
    if ((a % size_m(f3)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic bit cross_m(input logic [2:0] f3, input logic [31:0] a);
    return ((a % 4) + size_m(f3)) > 4;
  endfunction

  function automatic logic [31:0] data_m(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b0, input logic [31:0] b1);
    logic [63:0] dbl;
    logic [63:0] mask;
    logic [63:0] raw;
    int          sz;
    int          off;
    dbl  = {b1, b0};
    sz   = size_m(f3);
    off  = a % 4;
    mask = (64'd1 << (8 * sz)) - 64'd1;
    raw  = (dbl >> (8 * off)) & mask;
    if (!f3[2] && raw[8 * sz - 1]) raw = raw | ~mask;
    return raw[31:0];
  endfunction

  // ---------------- one complete load transaction ----------------
  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                         input logic [31:0] b0, input logic [31:0] b1,
                         input int gnt_dly, input int rdy_dly, input bit stray,
                         output logic [31:0] got_data, output logic got_fault);
    bit          e_fault;
    bit          e_cross;
    logic [31:0] e_data;
    logic [31:0] e_a0;
    e_fault = fault_m(f3, a);
    e_cross = !e_fault && cross_m(f3, a);
    e_data  = e_fault ? 32'd0 : data_m(f3, a, b0, b1);
    e_a0    = a & 32'hFFFF_FFFC;

    @(negedge clk);
    if (stray) begin
      bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = $urandom;
      @(negedge clk);
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      check("idle_stray_memreq", 32'(bus.mem_req), 32'd0);
      check("idle_stray_rspvalid", 32'(bus.rsp_valid), 32'd0);
    end
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.funct3 = f3; bus.addr = a; bus.rd_idx = rd;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.funct3 = 3'($urandom); bus.addr = $urandom; bus.rd_idx = 5'($urandom);

    if (e_fault) begin
      check("fault_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("fault_mem_req", 32'(bus.mem_req), 32'd0);
    end else begin
      check("req1_mem_req", 32'(bus.mem_req), 32'd1);
      check("req1_mem_addr", bus.mem_addr, e_a0);
      check("req1_req_ready", 32'(bus.req_ready), 32'd0);
      for (int i = 0; i < gnt_dly; i++) begin
        bus.mem_rvalid = stray;
        @(negedge clk);
        check("hold_mem_req", 32'(bus.mem_req), 32'd1);
        check("hold_mem_addr", bus.mem_addr, e_a0);
      end
      bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b1;
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      check("wait1_mem_req", 32'(bus.mem_req), 32'd0);
      check("wait1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      bus.mem_rvalid = 1'b1; bus.mem_rdata = b0;
      @(negedge clk);
      bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
      if (e_cross) begin
        check("req2_mem_req", 32'(bus.mem_req), 32'd1);
        check("req2_mem_addr", bus.mem_addr, e_a0 + 32'd4);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
      end
      check("resp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("resp_mem_req", 32'(bus.mem_req), 32'd0);
    end
    check("resp_fault", 32'(bus.rsp_fault), 32'(e_fault));
    check("resp_data", bus.rsp_data, e_data);
    check("resp_rd", 32'(bus.rsp_rd), 32'(rd));
    got_data  = bus.rsp_data;
    got_fault = bus.rsp_fault;

    for (int i = 0; i < rdy_dly; i++) begin
      bus.mem_gnt = stray; bus.mem_rvalid = stray;
      @(negedge clk);
      check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_rsp_data", bus.rsp_data, e_data);
      check("stall_rsp_rd", 32'(bus.rsp_rd), 32'(rd));
      check("stall_rsp_fault", 32'(bus.rsp_fault), 32'(e_fault));
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("done_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
    check({tag, "_rsp_rd"}, 32'(bus.rsp_rd), 32'd0);
    check({tag, "_rsp_fault"}, 32'(bus.rsp_fault), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic        f;
    logic [2:0]  rf3;
    logic [31:0] ra;

    errors = 0; checks = 0;
    clk = 1'b0; reset = 1'b1;
    bus.req_valid = 1'b0; bus.funct3 = 3'd0; bus.addr = 32'd0; bus.rd_idx = 5'd0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Byte/half extraction and extension from one word.
    do_load(3'b000, 32'h0000_1002, 5'd3, 32'h80FF_1234, 32'd0, 0, 0, 1'b0, d, f);
    check("lb_const", d, 32'hFFFF_FFFF);
    do_load(3'b100, 32'h0000_1002, 5'd4, 32'h80FF_1234, 32'd0, 0, 0, 1'b0, d, f);
    check("lbu_const", d, 32'h0000_00FF);
    do_load(3'b101, 32'h0000_1002, 5'd5, 32'h80FF_1234, 32'd0, 0, 0, 1'b0, d, f);
    check("lhu_const", d, 32'h0000_80FF);
    do_load(3'b001, 32'h0000_1002, 5'd6, 32'h80FF_1234, 32'd0, 0, 0, 1'b0, d, f);
    check("lh_const", d, 32'hFFFF_80FF);

    // Halfword straddling a word boundary.
    do_load(3'b001, 32'h0000_1003, 5'd7, 32'hAB00_0000, 32'h0000_00CD, 0, 0, 1'b0, d, f);
`ifdef MISALIGNED_SPLIT_EN
    check("split_lh_const", d, 32'hFFFF_CDAB);
`else
    check("misaligned_fault_const", 32'(f), 32'd1);
    check("misaligned_data_const", d, 32'd0);
`endif

    // Encodings illegal at XLEN=32.
    do_load(3'b011, 32'h0000_1000, 5'd8, 32'd0, 32'd0, 0, 0, 1'b0, d, f);
    check("ld_fault_const", 32'(f), 32'd1);
    do_load(3'b111, 32'h0000_1000, 5'd9, 32'd0, 32'd0, 0, 0, 1'b0, d, f);
    check("f111_fault_const", 32'(f), 32'd1);

    // Back-pressure on both the memory grant and the consumer.
    do_load(3'b010, 32'h0000_3000, 5'd10, 32'hCAFE_F00D, 32'd0, 4, 3, 1'b1, d, f);

    // Reset in WAIT1 abandons the access; a late read beat is ignored.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h0000_1000; bus.rd_idx = 5'd11;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("midreset");
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("stale_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("stale_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    check("stale_rsp_valid2", 32'(bus.rsp_valid), 32'd0);
    do_load(3'b010, 32'h0000_2000, 5'd12, 32'h1234_5678, 32'd0, 0, 0, 1'b0, d, f);
    check("post_reset_lw_const", d, 32'h1234_5678);

    // Randomized loads against the reference model.
    for (int n = 0; n < 60; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      if (n % 4 == 0) ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      if (n % 2 == 1) ra = ra & ~(32'(size_m(rf3)) - 32'd1);
      do_load(rf3, ra, 5'($urandom), $urandom, $urandom,
              $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), d, f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
